// File: rtl/rvfi_insn_queue_check_if.sv
// Bundle between rvfi_insn_queue_check and its environment: RVFI trace in,
// spec-model request/response handshake, and the error/count status out.
interface rvfi_insn_queue_check_if #(
  parameter int NRET    = 1,
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64
);
  localparam int MW = XLEN / 8;

  logic                    enable;
  logic [NRET-1:0]         rvfi_valid;
  logic [NRET*ORDER_W-1:0] rvfi_order;
  logic [NRET*32-1:0]      rvfi_insn;
  logic [NRET*5-1:0]       rvfi_rs1;
  logic [NRET*5-1:0]       rvfi_rs2;
  logic [NRET*5-1:0]       rvfi_rd;
  logic [NRET*XLEN-1:0]    rvfi_pre_pc;
  logic [NRET*XLEN-1:0]    rvfi_pre_rs1;
  logic [NRET*XLEN-1:0]    rvfi_pre_rs2;
  logic [NRET*XLEN-1:0]    rvfi_post_pc;
  logic [NRET*XLEN-1:0]    rvfi_post_rd;
  logic [NRET-1:0]         rvfi_trap;
  logic [NRET*XLEN-1:0]    rvfi_mem_addr;
  logic [NRET*MW-1:0]      rvfi_mem_rmask;
  logic [NRET*MW-1:0]      rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]    rvfi_mem_rdata;
  logic [NRET*XLEN-1:0]    rvfi_mem_wdata;

  logic                    req_valid;
  logic                    req_ready;
  logic [31:0]             req_insn;
  logic [XLEN-1:0]         req_pc;
  logic [XLEN-1:0]         req_rs1;
  logic [XLEN-1:0]         req_rs2;
  logic [XLEN-1:0]         req_mem_rdata;

  logic                    rsp_valid;
  logic                    rsp_spec_valid;
  logic [4:0]              rsp_rs1;
  logic [4:0]              rsp_rs2;
  logic [4:0]              rsp_rd;
  logic [XLEN-1:0]         rsp_post_rd;
  logic [XLEN-1:0]         rsp_post_pc;
  logic                    rsp_trap;
  logic [XLEN-1:0]         rsp_mem_addr;
  logic [MW-1:0]           rsp_mem_rmask;
  logic [MW-1:0]           rsp_mem_wmask;
  logic [XLEN-1:0]         rsp_mem_wdata;

  logic                    err;
  logic [3:0]              err_code;
  logic [ORDER_W-1:0]      err_order;
  logic [31:0]             checked_count;

  modport master (
    input  enable, rvfi_valid, rvfi_order, rvfi_insn, rvfi_rs1, rvfi_rs2, rvfi_rd,
           rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd, rvfi_trap,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata,
           req_ready, rsp_valid, rsp_spec_valid, rsp_rs1, rsp_rs2, rsp_rd, rsp_post_rd,
           rsp_post_pc, rsp_trap, rsp_mem_addr, rsp_mem_rmask, rsp_mem_wmask, rsp_mem_wdata,
    output req_valid, req_insn, req_pc, req_rs1, req_rs2, req_mem_rdata,
           err, err_code, err_order, checked_count
  );

  modport slave (
    output enable, rvfi_valid, rvfi_order, rvfi_insn, rvfi_rs1, rvfi_rs2, rvfi_rd,
           rvfi_pre_pc, rvfi_pre_rs1, rvfi_pre_rs2, rvfi_post_pc, rvfi_post_rd, rvfi_trap,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata,
           req_ready, rsp_valid, rsp_spec_valid, rsp_rs1, rsp_rs2, rsp_rd, rsp_post_rd,
           rsp_post_pc, rsp_trap, rsp_mem_addr, rsp_mem_rmask, rsp_mem_wmask, rsp_mem_wdata,
    input  req_valid, req_insn, req_pc, req_rs1, req_rs2, req_mem_rdata,
           err, err_code, err_order, checked_count
  );
endinterface

// File: rtl/rvfi_insn_queue_check.sv
// Queues RVFI retirements and checks each one against an external spec model's response.
// Define RVFI_QCHECK_ASSERT_EN to add a per-cycle assertion that no error has been flagged.
module rvfi_insn_queue_check #(
  parameter int NRET    = 1,
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64,
  parameter int DEPTH   = 8
) (
  input logic                     clk,
  input logic                     resetn,
  rvfi_insn_queue_check_if.master bus
);
  localparam int MW = XLEN / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [ORDER_W-1:0] order;
    logic [31:0]        insn;
    logic [4:0]         rs1, rs2, rd;
    logic [XLEN-1:0]    pre_pc, pre_rs1, pre_rs2, post_pc, post_rd;
    logic               trap;
    logic [XLEN-1:0]    mem_addr;
    logic [MW-1:0]      rmask, wmask;
    logic [XLEN-1:0]    rdata, wdata;
  } entry_t;

  typedef struct packed {
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] post_rd, post_pc;
    logic            trap;
    logic [XLEN-1:0] mem_addr;
    logic [MW-1:0]   rmask, wmask;
    logic [XLEN-1:0] wdata;
  } rsp_t;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ERR} state_t;

  // Lowest-numbered mismatch wins when several fields disagree.
  function automatic logic [3:0] f_code(input entry_t e, input rsp_t s, input logic order_bad);
    logic [11:1] hit;
    logic [3:0]  code;
    hit = '0;
    hit[1] = (s.rs1 != 5'd0) && (e.rs1 != s.rs1);
    hit[2] = (s.rs2 != 5'd0) && (e.rs2 != s.rs2);
    hit[3] = !s.trap && (e.rd != s.rd);
    hit[4] = !s.trap && (e.post_rd != s.post_rd);
    hit[5] = !s.trap && (e.post_pc != s.post_pc);
    hit[6] = ((s.rmask | s.wmask) != '0) && (e.mem_addr != s.mem_addr);
    for (int i = 0; i < MW; i++) begin
      if (s.wmask[i]) begin
        if (!e.wmask[i]) hit[7] = 1'b1;
        if (e.wdata[8*i +: 8] != s.wdata[8*i +: 8]) hit[8] = 1'b1;
      end else if (e.wmask[i]) begin
        if (!e.rmask[i] || (e.rdata[8*i +: 8] != e.wdata[8*i +: 8])) hit[8] = 1'b1;
      end
      if (s.rmask[i] && !e.rmask[i]) hit[9] = 1'b1;
    end
    hit[10] = (e.trap != s.trap);
    hit[11] = order_bad;
    code = 4'd0;
    for (int k = 11; k >= 1; k--) begin
      if (hit[k]) code = 4'(k);
    end
    return code;
  endfunction

  state_t             r_state, w_state_nxt;
  entry_t             r_q [DEPTH];
  logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_seeded;
  logic [ORDER_W-1:0] r_order_exp;
  logic               r_err;
  logic [3:0]         r_err_code;
  logic [ORDER_W-1:0] r_err_order;
  logic [31:0]        r_checked;

  entry_t             w_in [NRET];
  logic [AW-1:0]      w_slot [NRET];
  entry_t             w_head;
  rsp_t               w_rsp;
  logic [CW-1:0]      w_npush, w_free;
  logic [ORDER_W-1:0] w_ovf_order;
  logic               w_ovf, w_push, w_req_valid, w_fire, w_fail, w_pass;
  logic [3:0]         w_code;

  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      w_in[c].order    = bus.rvfi_order[c*ORDER_W +: ORDER_W];
      w_in[c].insn     = bus.rvfi_insn[c*32 +: 32];
      w_in[c].rs1      = bus.rvfi_rs1[c*5 +: 5];
      w_in[c].rs2      = bus.rvfi_rs2[c*5 +: 5];
      w_in[c].rd       = bus.rvfi_rd[c*5 +: 5];
      w_in[c].pre_pc   = bus.rvfi_pre_pc[c*XLEN +: XLEN];
      w_in[c].pre_rs1  = bus.rvfi_pre_rs1[c*XLEN +: XLEN];
      w_in[c].pre_rs2  = bus.rvfi_pre_rs2[c*XLEN +: XLEN];
      w_in[c].post_pc  = bus.rvfi_post_pc[c*XLEN +: XLEN];
      w_in[c].post_rd  = bus.rvfi_post_rd[c*XLEN +: XLEN];
      w_in[c].trap     = bus.rvfi_trap[c];
      w_in[c].mem_addr = bus.rvfi_mem_addr[c*XLEN +: XLEN];
      w_in[c].rmask    = bus.rvfi_mem_rmask[c*MW +: MW];
      w_in[c].wmask    = bus.rvfi_mem_wmask[c*MW +: MW];
      w_in[c].rdata    = bus.rvfi_mem_rdata[c*XLEN +: XLEN];
      w_in[c].wdata    = bus.rvfi_mem_wdata[c*XLEN +: XLEN];
    end
  end

  // Valid channels pack into consecutive slots; free space is judged before this cycle's pop.
  always_comb begin
    w_npush     = '0;
    w_ovf_order = '0;
    for (int c = 0; c < NRET; c++) begin
      w_slot[c] = r_wr_ptr + w_npush[AW-1:0];
      if (bus.rvfi_valid[c]) begin
        if (w_npush == '0) w_ovf_order = w_in[c].order;
        w_npush = w_npush + 1'b1;
      end
    end
    if (!bus.enable || (r_state == S_ERR)) w_npush = '0;
    w_free = CW'(DEPTH) - r_count;
    w_ovf  = (w_npush > w_free);
    w_push = (w_npush != '0) && !w_ovf;
  end

  always_comb begin
    w_rsp.rs1      = bus.rsp_rs1;
    w_rsp.rs2      = bus.rsp_rs2;
    w_rsp.rd       = bus.rsp_rd;
    w_rsp.post_rd  = bus.rsp_post_rd;
    w_rsp.post_pc  = bus.rsp_post_pc;
    w_rsp.trap     = bus.rsp_trap;
    w_rsp.mem_addr = bus.rsp_mem_addr;
    w_rsp.rmask    = bus.rsp_mem_rmask;
    w_rsp.wmask    = bus.rsp_mem_wmask;
    w_rsp.wdata    = bus.rsp_mem_wdata;
  end

  assign w_head = r_q[r_rd_ptr];
  assign w_fire = (r_state == S_WAIT) && bus.rsp_valid;
  assign w_code = f_code(w_head, w_rsp, r_seeded && (w_head.order != r_order_exp));
  assign w_fail = w_fire && bus.rsp_spec_valid && (w_code != 4'd0);
  assign w_pass = w_fire && bus.rsp_spec_valid && (w_code == 4'd0);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_REQ;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_req_valid = (r_count != '0);
        if (w_ovf)                           w_state_nxt = S_ERR;
        else if (w_req_valid && bus.req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_ovf || w_fail) w_state_nxt = S_ERR;
        else if (w_fire)     w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_seeded    <= 1'b0;
      r_order_exp <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 4'd0;
      r_err_order <= '0;
      r_checked   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + w_npush[AW-1:0];
      if (w_fire) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_seeded    <= 1'b1;
        r_order_exp <= w_head.order + 1'b1;
      end
      r_count <= r_count + (w_push ? w_npush : CW'(0)) - CW'(w_fire);
      if (w_fail) begin
        r_err       <= 1'b1;
        r_err_code  <= w_code;
        r_err_order <= w_head.order;
      end else if (w_ovf) begin
        r_err       <= 1'b1;
        r_err_code  <= 4'd12;
        r_err_order <= w_ovf_order;
      end
      if (w_pass && (r_checked != 32'hFFFF_FFFF)) r_checked <= r_checked + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      for (int c = 0; c < NRET; c++) begin
        if (bus.rvfi_valid[c]) r_q[w_slot[c]] <= w_in[c];
      end
    end
  end

  assign bus.req_valid     = w_req_valid;
  assign bus.req_insn      = w_head.insn;
  assign bus.req_pc        = w_head.pre_pc;
  assign bus.req_rs1       = w_head.pre_rs1;
  assign bus.req_rs2       = w_head.pre_rs2;
  assign bus.req_mem_rdata = w_head.rdata;
  assign bus.err           = r_err;
  assign bus.err_code      = r_err_code;
  assign bus.err_order     = r_err_order;
  assign bus.checked_count = r_checked;

`ifdef RVFI_QCHECK_ASSERT_EN
  logic r_past_resetn;
  always_ff @(posedge clk) r_past_resetn <= resetn;
  always @(posedge clk) begin
    if (r_past_resetn) assert (!r_err);
  end
`else
`endif

endmodule

// File: tb/tb_rvfi_insn_queue_check.sv
// Bench for rvfi_insn_queue_check: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
module tb_rvfi_insn_queue_check;
  localparam int NRET = 2, XLEN = 32, ORDER_W = 64, DEPTH = 4, MW = XLEN / 8;

  typedef struct packed {
    logic [63:0] order; logic [31:0] insn; logic [4:0] rs1, rs2, rd;
    logic [31:0] pre_pc, pre_rs1, pre_rs2, post_pc, post_rd; logic trap;
    logic [31:0] mem_addr; logic [3:0] rmask, wmask; logic [31:0] rdata, wdata;
  } ent_t;

  typedef struct packed {
    logic spec_valid; logic [4:0] rs1, rs2, rd; logic [31:0] post_rd, post_pc; logic trap;
    logic [31:0] mem_addr; logic [3:0] rmask, wmask; logic [31:0] wdata;
  } rsp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  rvfi_insn_queue_check_if #(.NRET(NRET), .XLEN(XLEN), .ORDER_W(ORDER_W)) bus ();

  rvfi_insn_queue_check #(.NRET(NRET), .XLEN(XLEN), .ORDER_W(ORDER_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.master)
  );

  int n_chk = 0, n_err = 0;

  // reference model state
  ent_t        mq[$];
  bit          m_err, m_seeded, outst;
  int          m_code;
  logic [63:0] m_err_order, m_exp;
  logic [31:0] m_count;
  ent_t        infl;
  int          wait_left;

  // stimulus knobs
  ent_t        pend [NRET];
  logic [1:0]  pend_v = '0;
  logic        pend_en = 1'b1;
  int          ready_pct = 100, wait_max = 0, sv_pct = 100, inject = 0;
  bit          force_junk = 0, hold_rsp = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic ent_t rand_ent(input logic [63:0] ord);
    ent_t e;
    e.order = ord; e.insn = $urandom; e.rs1 = 5'($urandom); e.rs2 = 5'($urandom); e.rd = 5'($urandom);
    e.pre_pc = $urandom; e.pre_rs1 = $urandom; e.pre_rs2 = $urandom;
    e.post_pc = $urandom; e.post_rd = $urandom; e.trap = ($urandom_range(0, 7) == 0);
    e.mem_addr = $urandom; e.rmask = 4'($urandom); e.wmask = 4'($urandom);
    e.rdata = $urandom; e.wdata = $urandom;
    return e;
  endfunction

  function automatic rsp_t match_rsp(input ent_t e);
    rsp_t r;
    r.spec_valid = 1'b1; r.rs1 = e.rs1; r.rs2 = e.rs2; r.rd = e.rd;
    r.post_rd = e.post_rd; r.post_pc = e.post_pc; r.trap = e.trap; r.mem_addr = e.mem_addr;
    r.rmask = e.rmask; r.wmask = e.wmask; r.wdata = e.wdata;
    return r;
  endfunction

  // Expected error code, checked rule by rule; the first rule that fails is the lowest code.
  function automatic int exp_code(input ent_t e, input rsp_t s, input bit bad_order);
    if (s.rs1 != 0 && s.rs1 != e.rs1) return 1;
    if (s.rs2 != 0 && s.rs2 != e.rs2) return 2;
    if (!s.trap && s.rd != e.rd) return 3;
    if (!s.trap && s.post_rd != e.post_rd) return 4;
    if (!s.trap && s.post_pc != e.post_pc) return 5;
    if ((s.rmask | s.wmask) != 0 && s.mem_addr != e.mem_addr) return 6;
    for (int i = 0; i < MW; i++) if (s.wmask[i] && !e.wmask[i]) return 7;
    for (int i = 0; i < MW; i++) begin
      if (s.wmask[i] && e.wdata[8*i +: 8] != s.wdata[8*i +: 8]) return 8;
      if (!s.wmask[i] && e.wmask[i] && (!e.rmask[i] || e.rdata[8*i +: 8] != e.wdata[8*i +: 8])) return 8;
    end
    for (int i = 0; i < MW; i++) if (s.rmask[i] && !e.rmask[i]) return 9;
    if (s.trap != e.trap) return 10;
    if (bad_order) return 11;
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete(); m_err = 0; m_code = 0; m_err_order = '0; m_count = '0;
    m_seeded = 0; m_exp = '0; outst = 0; wait_left = 0;
  endtask

  task automatic cycle();
    rsp_t r; ent_t e, head; bit fire, acc, ovf, err_pre, rv; int n, code;
    bus.enable = pend_en; bus.rvfi_valid = pend_v;
    for (int c = 0; c < NRET; c++) begin
      bus.rvfi_order[c*64 +: 64] = pend[c].order;     bus.rvfi_insn[c*32 +: 32] = pend[c].insn;
      bus.rvfi_rs1[c*5 +: 5] = pend[c].rs1;            bus.rvfi_rs2[c*5 +: 5] = pend[c].rs2;
      bus.rvfi_rd[c*5 +: 5] = pend[c].rd;              bus.rvfi_pre_pc[c*32 +: 32] = pend[c].pre_pc;
      bus.rvfi_pre_rs1[c*32 +: 32] = pend[c].pre_rs1;  bus.rvfi_pre_rs2[c*32 +: 32] = pend[c].pre_rs2;
      bus.rvfi_post_pc[c*32 +: 32] = pend[c].post_pc;  bus.rvfi_post_rd[c*32 +: 32] = pend[c].post_rd;
      bus.rvfi_trap[c] = pend[c].trap;                 bus.rvfi_mem_addr[c*32 +: 32] = pend[c].mem_addr;
      bus.rvfi_mem_rmask[c*4 +: 4] = pend[c].rmask;    bus.rvfi_mem_wmask[c*4 +: 4] = pend[c].wmask;
      bus.rvfi_mem_rdata[c*32 +: 32] = pend[c].rdata;  bus.rvfi_mem_wdata[c*32 +: 32] = pend[c].wdata;
    end
    bus.req_ready = ($urandom_range(0, 99) < ready_pct);
    if (outst && wait_left == 0 && !hold_rsp) begin
      r = match_rsp(infl);
      r.spec_valid = ($urandom_range(0, 99) < sv_pct);
      if (inject == 4) begin r.post_rd = infl.post_rd ^ 32'h1; r.trap = 1'b0; end
      if (inject == 7) r.wmask = infl.wmask | 4'h2;
      if (inject == 8) r.wmask = 4'h0;
      bus.rsp_valid = 1'b1;
    end else begin
      r = match_rsp(rand_ent($urandom));
      bus.rsp_valid = !outst && (force_junk || $urandom_range(0, 9) == 0);
      if (outst && wait_left > 0) wait_left--;
    end
    bus.rsp_spec_valid = r.spec_valid; bus.rsp_rs1 = r.rs1; bus.rsp_rs2 = r.rs2; bus.rsp_rd = r.rd;
    bus.rsp_post_rd = r.post_rd; bus.rsp_post_pc = r.post_pc; bus.rsp_trap = r.trap;
    bus.rsp_mem_addr = r.mem_addr; bus.rsp_mem_rmask = r.rmask; bus.rsp_mem_wmask = r.wmask;
    bus.rsp_mem_wdata = r.wdata;
    @(posedge clk);
    if (!resetn) model_reset();
    else begin
      err_pre = m_err;
      fire = outst && !err_pre && bus.rsp_valid;
      acc  = !outst && !err_pre && mq.size() > 0 && bus.req_ready;
      if (mq.size() > 0) head = mq[0];
      n    = (pend_en && !err_pre) ? $countones(pend_v) : 0;
      ovf  = n > (DEPTH - mq.size());
      if (fire) begin
        e = mq.pop_front(); outst = 0; inject = 0;
        if (r.spec_valid) begin
          code = exp_code(e, r, m_seeded && e.order != m_exp);
          if (code == 0) begin
            if (m_count != 32'hFFFF_FFFF) m_count++;
          end else begin
            m_err = 1; m_code = code; m_err_order = e.order;
          end
        end
        m_seeded = 1; m_exp = e.order + 64'd1;
      end
      if (ovf) begin
        if (!m_err) begin m_err = 1; m_code = 12; end
      end else if (n > 0) begin
        for (int c = 0; c < NRET; c++) if (pend_v[c]) mq.push_back(pend[c]);
      end
      if (acc) begin outst = 1; infl = head; wait_left = $urandom_range(0, wait_max); end
    end
    pend_v = '0;
    @(negedge clk);
    check("err", bus.err, m_err);
    check("err_code", bus.err_code, m_code);
    if (m_err && m_code != 12) check("err_order", bus.err_order, m_err_order);
    check("checked_count", bus.checked_count, m_count);
    rv = resetn && !outst && !m_err && mq.size() > 0;
    check("req_valid", bus.req_valid, rv);
    if (rv) begin
      check("req_insn", bus.req_insn, mq[0].insn);
      check("req_pc", bus.req_pc, mq[0].pre_pc);
      check("req_rs1", bus.req_rs1, mq[0].pre_rs1);
      check("req_rs2", bus.req_rs2, mq[0].pre_rs2);
      check("req_mem_rdata", bus.req_mem_rdata, mq[0].rdata);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; cycle(); cycle(); resetn = 1'b1;
    ready_pct = 100; wait_max = 0; sv_pct = 100; inject = 0; force_junk = 0; hold_rsp = 0; pend_en = 1'b1;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  logic [63:0] ord;

  initial begin
    for (int c = 0; c < NRET; c++) pend[c] = rand_ent(0);
    model_reset();
    do_reset();
    check("rst_err", bus.err, 0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_err_order", bus.err_order, 0);
    check("rst_count", bus.checked_count, 0);
    check("rst_req_valid", bus.req_valid, 0);

    // two channels, orders 5 and 6, immediate ready and response
    pend[0] = rand_ent(64'd5); pend[1] = rand_ent(64'd6); pend_v = 2'b11;
    cycle();
    check("lat_req_valid", bus.req_valid, 1);
    run(2);
    check("lat_count1", bus.checked_count, 1);
    run(2);
    check("tp_count2", bus.checked_count, 2);
    check("tp_err0", bus.err, 0);

    // post_rd mismatch
    do_reset();
    pend[0] = rand_ent(64'd10); pend[0].trap = 1'b0; pend[0].post_rd = 32'h11; pend_v = 2'b01;
    inject = 4;
    run(3);
    check("postrd_code", bus.err_code, 4);
    check("postrd_order", bus.err_order, 64'd10);
    pend[0] = rand_ent(64'd11); pend_v = 2'b01;
    run(3);
    check("postrd_req_off", bus.req_valid, 0);

    // order gap
    do_reset();
    pend[0] = rand_ent(64'd3); pend_v = 2'b01; cycle();
    pend[0] = rand_ent(64'd5); pend_v = 2'b01; run(5);
    check("order_code", bus.err_code, 11);
    check("order_err_order", bus.err_order, 64'd5);

    // overflow with ready held low
    do_reset();
    ready_pct = 0;
    for (int i = 0; i < 4; i++) begin pend[0] = rand_ent(64'(i)); pend_v = 2'b01; cycle(); end
    check("ovf_before", bus.err, 0);
    pend[0] = rand_ent(64'd4); pend_v = 2'b01; cycle();
    check("ovf_code", bus.err_code, 12);

    // spec store wider than trace store
    do_reset();
    pend[0] = rand_ent(64'd20); pend[0].wmask = 4'h1; pend_v = 2'b01;
    inject = 7; run(3);
    check("wmask_code", bus.err_code, 7);

    // trace-only written byte whose data changed
    do_reset();
    pend[0] = rand_ent(64'd30); pend[0].wmask = 4'h1; pend[0].rmask = 4'h1;
    pend[0].rdata[7:0] = ~pend[0].wdata[7:0]; pend_v = 2'b01;
    inject = 8; run(3);
    check("wdata_code", bus.err_code, 8);

    // reset while waiting for a response, then a stray response
    do_reset();
    pend[0] = rand_ent(64'd40); pend_v = 2'b01; hold_rsp = 1; run(2);
    resetn = 1'b0; cycle(); resetn = 1'b1;
    force_junk = 1; cycle(); force_junk = 0; hold_rsp = 0;
    check("midrst_err", bus.err, 0);
    check("midrst_count", bus.checked_count, 0);
    check("midrst_req_valid", bus.req_valid, 0);
    pend[0] = rand_ent(64'd77); pend_v = 2'b01; run(3);
    check("midrst_reseed", bus.checked_count, 1);

    // randomized traffic with order wrap-around
    do_reset();
    ready_pct = 60; wait_max = 3; sv_pct = 85;
    ord = 64'hFFFF_FFFF_FFFF_FFFD;
    for (int i = 0; i < 800; i++) begin
      pend_en = ($urandom_range(0, 9) != 0);
      pend_v = 2'($urandom);
      if ($countones(pend_v) > DEPTH - mq.size()) pend_v = '0;
      for (int c = 0; c < NRET; c++) begin
        pend[c] = rand_ent(ord);
        if (pend_v[c] && pend_en) ord = ord + 64'd1;
      end
      cycle();
    end
    check("rand_no_err", bus.err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
